// File: rtl/pwm_ctrl_pkg.sv
// Shared types and helpers for the PWM ramp controller.
// Duty values are offset-binary: MID = zero drive, above/below MID = direction A/B.
package pwm_ctrl_pkg;

  localparam int DUTY_W = 16;

  typedef enum logic [1:0] {
    HOLD,
    RAMP,
    DWELL
  } state_e;

  function automatic logic [DUTY_W-1:0] mid_of(input int max_count);
    return DUTY_W'(max_count / 2);
  endfunction

endpackage

// File: rtl/pwm_ramp_controller_if.sv
// Duty command handshake between the command source (master) and the ramp controller (slave).
interface pwm_ramp_controller_if
  import pwm_ctrl_pkg::*;
();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DUTY_W-1:0] cmd_duty;

  modport master (output cmd_valid, output cmd_duty, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_duty, output cmd_ready);

endinterface

// File: rtl/pwm_period_timer.sv
// PWM period counter (0..MAX_COUNT-1) with a one-cycle period_tick on the last count,
// plus a RAMP_DIV prescaler producing ramp_tick on every RAMP_DIV-th period_tick.
module pwm_period_timer #(
  parameter int MAX_COUNT = 4096,
  parameter int RAMP_DIV  = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic period_tick,
  output logic ramp_tick
);

  localparam int CNT_W = $clog2(MAX_COUNT);
  localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             pre_wrap;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    pre_d       = pre_q;
    period_tick = (cnt_q == CNT_W'(MAX_COUNT - 1));
    pre_wrap    = (pre_q == PRE_W'(RAMP_DIV - 1));
    ramp_tick   = period_tick && pre_wrap;
    cnt_d       = period_tick ? '0 : cnt_q + 1'b1;
    if (period_tick) begin
      pre_d = pre_wrap ? '0 : pre_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      pre_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/pwm_ramp_controller.sv
// Slews duty_cycle toward the commanded target in STEP increments on ramp ticks,
// dwelling at MID for DEAD_PERIODS before any direction reversal.
// Optional watchdog: define PWM_RAMP_WDT_EN to return to MID when commands stop.
module pwm_ramp_controller
  import pwm_ctrl_pkg::*;
#(
  parameter int MAX_COUNT    = 4096,
  parameter int STEP         = 256,
  parameter int RAMP_DIV     = 1,
  parameter int DEAD_PERIODS = 2,
  parameter int WDT_PERIODS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pwm_ramp_controller_if.slave  cmd,
  output logic [DUTY_W-1:0]     duty_cycle,
  output logic                  busy,
  output logic                  wdt_fault
);

  localparam logic [DUTY_W-1:0]   MID    = mid_of(MAX_COUNT);
  localparam logic [DUTY_W-1:0]   MAX_D  = DUTY_W'(MAX_COUNT);
  localparam logic [DUTY_W-1:0]   STEP_D = DUTY_W'(STEP);
  localparam logic signed [DUTY_W:0] STEP_S = (DUTY_W+1)'(STEP);
  localparam int                  DEAD_W = $clog2(DEAD_PERIODS + 1);

  state_e            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [DEAD_W-1:0] dead_q, dead_d;

  logic                     period_tick, ramp_tick;
  logic                     accept, wdt_trip, reversal;
  logic [DUTY_W-1:0]        tgt_in, goal, stepped;
  logic signed [DUTY_W:0]   diff;

  pwm_period_timer #(
    .MAX_COUNT (MAX_COUNT),
    .RAMP_DIV  (RAMP_DIV)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .period_tick (period_tick),
    .ramp_tick   (ramp_tick)
  );

  assign cmd.cmd_ready = (state_q != DWELL);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign tgt_in        = (cmd.cmd_duty > MAX_D) ? MAX_D : cmd.cmd_duty;
  assign duty_cycle    = duty_q;
  assign busy          = (state_q != HOLD);

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    dead_d   = dead_q;
    target_d = target_q;

    // The step uses the target held before this cycle; a command accepted now applies from the next tick.
    reversal = ((duty_q > MID) && (target_q < MID)) || ((duty_q < MID) && (target_q > MID));
    goal     = reversal ? MID : target_q;
    diff     = $signed({1'b0, goal}) - $signed({1'b0, duty_q});
    if (diff > STEP_S)       stepped = duty_q + STEP_D;
    else if (diff < -STEP_S) stepped = duty_q - STEP_D;
    else                     stepped = goal;

    if (wdt_trip) target_d = MID;
    if (accept)   target_d = tgt_in;

    case (state_q)
      HOLD: begin
        if (target_d != duty_q) state_d = RAMP;
      end
      RAMP: begin
        if (ramp_tick) duty_d = stepped;
        if (duty_d == target_d)             state_d = HOLD;
        else if (reversal && duty_d == MID) state_d = DWELL;
      end
      DWELL: begin
        if (period_tick) begin
          if (dead_q == DEAD_W'(DEAD_PERIODS - 1)) begin
            dead_d  = '0;
            state_d = (target_d == MID) ? HOLD : RAMP;
          end else begin
            dead_d = dead_q + 1'b1;
          end
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HOLD;
      duty_q   <= MID;
      target_q <= MID;
      dead_q   <= '0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      dead_q   <= dead_d;
    end
  end

`ifdef PWM_RAMP_WDT_EN
  localparam int WDT_W = $clog2(WDT_PERIODS + 1);

  logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
  logic             wdt_fault_q, wdt_fault_d;

  // An acceptance in the expiry cycle takes priority over the trip.
  always_comb begin
    wdt_cnt_d   = wdt_cnt_q;
    wdt_fault_d = wdt_fault_q;
    wdt_trip    = 1'b0;
    if (accept) begin
      wdt_cnt_d   = '0;
      wdt_fault_d = 1'b0;
    end else if (period_tick && !wdt_fault_q) begin
      if (wdt_cnt_q == WDT_W'(WDT_PERIODS - 1)) begin
        wdt_trip    = 1'b1;
        wdt_fault_d = 1'b1;
        wdt_cnt_d   = '0;
      end else begin
        wdt_cnt_d = wdt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_cnt_q   <= '0;
      wdt_fault_q <= 1'b0;
    end else begin
      wdt_cnt_q   <= wdt_cnt_d;
      wdt_fault_q <= wdt_fault_d;
    end
  end

  assign wdt_fault = wdt_fault_q;
`else
  logic unused_wdt_cfg;
  assign unused_wdt_cfg = (WDT_PERIODS > 0);
  assign wdt_trip       = 1'b0;
  assign wdt_fault      = 1'b0;
`endif

endmodule

// File: doc/pwm_ramp_controller.md
# pwm_ramp_controller

Sequencer for the H-bridge PWM_Generator: accepts duty commands via valid/ready handshake, slews the offset-binary `duty_cycle` toward the target in bounded steps aligned to PWM period boundaries, and forces a dead dwell at the midpoint (zero drive) before any direction reversal. Sits between the command source (software register or speed loop) and PWM_Generator, whose `duty_cycle` input it drives directly. An optional watchdog returns the motor to zero drive when commands stop arriving.

## Interface
- `MAX_COUNT`, 4096: PWM period in clocks; must match the driven PWM_Generator. Midpoint `MID = MAX_COUNT/2` means zero drive.
- `STEP`, 256: maximum duty change per ramp update.
- `RAMP_DIV`, 1: PWM periods between ramp updates (≥1).
- `DEAD_PERIODS`, 2: PWM periods held at MID during a reversal (≥1).
- `WDT_PERIODS`, 8: PWM periods without an accepted command before watchdog trips.
- `clk` in 1: system clock; same clock as PWM_Generator.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command can be accepted.
- `cmd_duty` in 16: target duty, offset-binary (>MID dir A, <MID dir B).
- `duty_cycle` out 16: registered duty to PWM_Generator.
- `busy` out 1: state ≠ HOLD.
- `wdt_fault` out 1: watchdog tripped (sticky until next accepted command).

## Operation
- Period timer: counter 0..MAX_COUNT-1, reset to 0, wraps; `period_tick` is a 1-cycle pulse when the count equals MAX_COUNT-1. Prescaler counts ticks modulo RAMP_DIV; `ramp_tick` = period_tick at prescaler wrap.
- Acceptance: `cmd_valid && cmd_ready`. Target latched as min(cmd_duty, MAX_COUNT). A new command mid-ramp retargets from the current duty; no restart.
- States:
  - HOLD: duty == target. Accept → RAMP if target ≠ duty.
  - RAMP: on each ramp_tick, move duty toward `goal` by up to STEP without overshoot (clamp to goal). `goal` = MID if duty and target lie strictly on opposite sides of MID, else target. Reaching MID with reversal pending → DWELL; reaching target → HOLD.
  - DWELL: duty held at MID; counts DEAD_PERIODS period_ticks, then → RAMP (or → HOLD if target == MID).
- `cmd_ready` = 1 in HOLD and RAMP, 0 in DWELL.
- Arithmetic: 17-bit internal difference; no wrap past 0 or MAX_COUNT.
- Reset values: duty_cycle = MID, state HOLD, target = MID, busy 0, cmd_ready 1, wdt_fault 0, all counters 0.

## Timing
- duty_cycle changes only in the cycle after a ramp_tick, so the PWM_Generator sees at most one change per period, at the period boundary.
- Acceptance → first step: ≤ RAMP_DIV periods plus 1 clock.
- Acceptance coinciding with ramp_tick: that step uses the old target; new target applies from the next ramp_tick.
- Ramp full-scale (MID → MAX_COUNT) = ceil(MID/STEP)·RAMP_DIV periods.
- Reset mid-operation: outputs return to reset values immediately (asynchronous), no ramp-down.

## Configuration
- `PWM_RAMP_WDT_EN` defined: period counter since last acceptance; reaching WDT_PERIODS sets wdt_fault and target = MID (normal ramp, reversal rules not needed since MID is never across). Acceptance clears wdt_fault and the counter; acceptance in the expiry cycle wins.
- Undefined: no watchdog logic; wdt_fault tied 0.

## Structure
- Package `pwm_ctrl_pkg`: state enum (HOLD, RAMP, DWELL), duty width constant (16), MID helper function.
- One sub-module: `pwm_period_timer` (period counter + period_tick + RAMP_DIV prescaler).

## Test plan
(MAX_COUNT=4096, STEP=256, RAMP_DIV=1, DEAD_PERIODS=2, WDT_PERIODS=8)
- Reset → duty_cycle 2048, busy 0, cmd_ready 1, wdt_fault 0.
- cmd 3072 → duty 2304, 2560, 2816, 3072 on consecutive period boundaries, then busy 0.
- From 3072, cmd 1024 → duty 2816…2048 (4 ticks), DWELL 2 periods with cmd_ready 0, then 1792…1024.
- cmd 3000 from 2048 → 2304, 2560, 2816, 3000; cmd 5000 → ramps and stops at 4096.
- PWM_RAMP_WDT_EN: at 3072, no commands for 8 periods → wdt_fault 1, ramps to 2048; next cmd clears fault.
- rst_n low mid-ramp (duty 2560) → duty_cycle 2048 asynchronously, state HOLD.
